// File: rtl/argmax_pkg.sv
// Shared constants and FSM state type for the argmax scheduler.
package argmax_pkg;

    localparam int DATA_WIDTH = 27;
    localparam int NUM_CLASS  = 10;
    localparam int IDX_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/signed_max_cell.sv
// Combinational signed compare/select of an incoming (score, index) against the stored best.
module signed_max_cell
    import argmax_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int IW = IDX_WIDTH
) (
    input  logic signed [DW-1:0] in_score_i,
    input  logic        [IW-1:0] in_idx_i,
    input  logic signed [DW-1:0] cur_score_i,
    input  logic        [IW-1:0] cur_idx_i,
    input  logic                 load_i,
    output logic signed [DW-1:0] sel_score_o,
    output logic        [IW-1:0] sel_idx_o
);

    logic take;

    // Strict greater-than so a tie keeps the earlier (lower) index.
    assign take        = load_i || (in_score_i > cur_score_i);
    assign sel_score_o = take ? in_score_i : cur_score_i;
    assign sel_idx_o   = take ? in_idx_i   : cur_idx_i;

endmodule

// File: rtl/argmax_scheduler.sv
// Streams NUM_CLASS signed scores per frame and reports the index/value of the largest one.
module argmax_scheduler #(
    parameter int DATA_WIDTH = argmax_pkg::DATA_WIDTH,
    parameter int NUM_CLASS  = argmax_pkg::NUM_CLASS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic signed [DATA_WIDTH-1:0] score_in,
    input  logic                         score_valid,
    output logic                         score_ready,
    output logic        [7:0]            predict,
    output logic signed [DATA_WIDTH-1:0] max_score,
    output logic                         predict_valid,
    input  logic                         predict_ack,
    output logic                         busy,
    output logic        [15:0]           img_count
);

    localparam int IW = argmax_pkg::IDX_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASS - 1);

    argmax_pkg::state_e state_q, state_d;
    logic        [IW-1:0]         idx_q, idx_d;
    logic        [IW-1:0]         best_q, best_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic        [15:0]           img_count_q, img_count_d;

    logic signed [DATA_WIDTH-1:0] cell_score;
    logic        [IW-1:0]         cell_idx;

    signed_max_cell #(
        .DW(DATA_WIDTH),
        .IW(IW)
    ) u_cell (
        .in_score_i (score_in),
        .in_idx_i   (idx_q),
        .cur_score_i(max_q),
        .cur_idx_i  (best_q),
        .load_i     (idx_q == '0),
        .sel_score_o(cell_score),
        .sel_idx_o  (cell_idx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_d      = best_q;
        max_d       = max_q;
        img_count_d = img_count_q;
        // abort outranks every other event in the same cycle
        if (abort) begin
            state_d = argmax_pkg::ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                argmax_pkg::ST_IDLE: begin
                    if (start) begin
                        state_d = argmax_pkg::ST_COLLECT;
                        idx_d   = '0;
                    end
                end
                argmax_pkg::ST_COLLECT: begin
                    if (score_valid) begin
                        max_d  = cell_score;
                        best_d = cell_idx;
                        if (idx_q == LAST_IDX) state_d = argmax_pkg::ST_DONE;
                        else                   idx_d   = idx_q + 1'b1;
                    end
                end
                argmax_pkg::ST_DONE: begin
                    if (predict_ack) begin
                        state_d     = argmax_pkg::ST_IDLE;
                        img_count_d = img_count_q + 16'd1;
                    end
                end
                default: state_d = argmax_pkg::ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= argmax_pkg::ST_IDLE;
            idx_q       <= '0;
            best_q      <= '0;
            max_q       <= '0;
            img_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            max_q       <= max_d;
            img_count_q <= img_count_d;
        end
    end

    // All outputs decode from flops only; score_in never reaches a port combinationally.
    assign score_ready   = (state_q == argmax_pkg::ST_COLLECT);
    assign predict_valid = (state_q == argmax_pkg::ST_DONE);
    assign busy          = (state_q != argmax_pkg::ST_IDLE);
    assign predict       = {{(8 - IW){1'b0}}, best_q};
    assign max_score     = max_q;
    assign img_count     = img_count_q;

endmodule

// File: tb/tb_argmax_scheduler.sv
// Scoreboard bench for argmax_scheduler: model results queued at stimulus time, popped at predict_valid.
module tb_argmax_scheduler;

    localparam int DW = 27;
    localparam int NC = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic signed [DW-1:0] score_in;
    logic                 score_valid;
    logic                 score_ready;
    logic        [7:0]    predict;
    logic signed [DW-1:0] max_score;
    logic                 predict_valid;
    logic                 predict_ack;
    logic                 busy;
    logic        [15:0]   img_count;

    argmax_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .score_in     (score_in),
        .score_valid  (score_valid),
        .score_ready  (score_ready),
        .predict      (predict),
        .max_score    (max_score),
        .predict_valid(predict_valid),
        .predict_ack  (predict_ack),
        .busy         (busy),
        .img_count    (img_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        [7:0]    idx;
        logic signed [DW-1:0] mx;
    } exp_t;

    exp_t                 sb[$];
    logic signed [DW-1:0] sc[NC];
    logic        [15:0]   exp_cnt;
    logic        [7:0]    last_pred;
    logic signed [DW-1:0] last_max;
    int                   checks   = 0;
    int                   failures = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic push_expected();
        exp_t e;
        e.idx = 8'd0;
        e.mx  = sc[0];
        for (int i = 1; i < NC; i++) begin
            if (sc[i] > e.mx) begin
                e.mx  = sc[i];
                e.idx = 8'(i);
            end
        end
        sb.push_back(e);
    endtask

    task automatic run_beats(input bit gaps, input bit ack_noise, output int cycles);
        int  b;
        int  cyc;
        bit  early;
        b     = 0;
        cyc   = 0;
        early = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (b < NC && cyc < 200) begin
            score_valid = gaps ? (cyc % 2 == 1) : 1'b1;
            score_in    = score_valid ? sc[b] : 27'sh3FFFFFF;
            predict_ack = ack_noise;
            if (predict_valid !== 1'b0) early = 1'b1;
            if (score_valid && score_ready) b++;
            @(negedge clk);
            cyc++;
        end
        score_valid = 1'b0;
        predict_ack = 1'b0;
        cycles      = cyc;
        checks++;
        if (b != NC || early) begin
            failures++;
            $display("FAIL collect: beats=%0d early_valid=%0b required beats=%0d early_valid=0", b, early, NC);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        checks++;
        if (predict_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid: predict_valid=%b required 1", name, predict_valid);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            last_pred = e.idx;
            last_max  = e.mx;
            if (predict !== e.idx || max_score !== e.mx) begin
                failures++;
                $display("FAIL %s_result: predict=%0d max=%0d required predict=%0d max=%0d",
                         name, predict, max_score, e.idx, e.mx);
            end
        end
    endtask

    task automatic do_ack(input string name);
        predict_ack = 1'b1;
        @(negedge clk);
        predict_ack = 1'b0;
        exp_cnt     = exp_cnt + 16'd1;
        checks++;
        if (predict_valid !== 1'b0 || busy !== 1'b0 || img_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s_ack: valid=%b busy=%b img_count=%h required 0 0 %h",
                     name, predict_valid, busy, img_count, exp_cnt);
        end
        checks++;
        if (predict !== last_pred || max_score !== last_max) begin
            failures++;
            $display("FAIL %s_retain: predict=%0d max=%0d required %0d %0d",
                     name, predict, max_score, last_pred, last_max);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (score_ready !== 1'b0 || predict !== 8'd0 || max_score !== '0 ||
            predict_valid !== 1'b0 || busy !== 1'b0 || img_count !== 16'd0) begin
            failures++;
            $display("FAIL %s: ready=%b predict=%0d max=%0d valid=%b busy=%b cnt=%h required all zero",
                     name, score_ready, predict, max_score, predict_valid, busy, img_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; score_valid = 1'b0;
        score_in = '0; predict_ack = 1'b0; exp_cnt = 16'd0;
        #1;
        check_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_idle");
    endtask

    task automatic test_basic();
        int cyc;
        sc = '{27'sd5, -27'sd3, 27'sd100, 27'sd7, 27'sd100, -27'sd1, 27'sd0, 27'sd99, 27'sd2, 27'sd1};
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        checks++;
        if (cyc != NC) begin
            failures++;
            $display("FAIL basic_cycles: cycles=%0d required %0d", cyc, NC);
        end
        check_result("basic");
        do_ack("basic");
    endtask

    task automatic test_all_min();
        int cyc;
        for (int i = 0; i < NC; i++) sc[i] = 27'sh4000000;
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        check_result("allmin");
        do_ack("allmin");
    endtask

    task automatic test_gaps();
        int cyc;
        for (int i = 0; i < NC - 1; i++) sc[i] = -27'sd10 * 27'(i + 1);
        sc[NC-1] = 27'sd1;
        push_expected();
        run_beats(1'b1, 1'b1, cyc);
        checks++;
        if (cyc != 2 * NC || img_count !== exp_cnt) begin
            failures++;
            $display("FAIL gaps_cycles: cycles=%0d img_count=%h required %0d %h", cyc, img_count, 2 * NC, exp_cnt);
        end
        check_result("gaps");
        do_ack("gaps");
    endtask

    task automatic test_abort();
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1;
            score_in    = 27'sd5000 + 27'(i);
            @(negedge clk);
        end
        score_in = 27'sd9000; abort = 1'b1; predict_ack = 1'b1;
        @(negedge clk);
        abort = 1'b0; score_valid = 1'b0; predict_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || predict_valid !== 1'b0 || score_ready !== 1'b0 || img_count !== exp_cnt) begin
            failures++;
            $display("FAIL abort_idle: busy=%b valid=%b ready=%b cnt=%h required 0 0 0 %h",
                     busy, predict_valid, score_ready, img_count, exp_cnt);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_over_start: busy=%b required 0", busy);
        end
        sc = '{-27'sd4, -27'sd8, 27'sd3, 27'sd12, -27'sd1, 27'sd11, 27'sd12, 27'sd0, 27'sd6, -27'sd20};
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        check_result("after_abort");
        do_ack("after_abort");
    endtask

    task automatic test_reset_mid();
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        score_valid = 1'b1;
        score_in = 27'sd77;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_mid");
        score_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'd0;
        score_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || score_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_needs_start: busy=%b ready=%b required 0 0", busy, score_ready);
        end
        score_valid = 1'b0;
        sc = '{27'sd1, 27'sd2, 27'sd3, 27'sd4, 27'sd5, 27'sd6, 27'sd7, 27'sd8, 27'sd9, 27'sd10};
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        check_result("pre_reset_done");
        #2 rst = 1'b1;
        #1 check_zero("reset_done");
        @(negedge clk);
        rst = 1'b0;
        sc = '{27'sd40, -27'sd2, 27'sd41, 27'sd3, 27'sd0, 27'sd41, 27'sd9, -27'sd50, 27'sd8, 27'sd2};
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        check_result("post_reset");
        do_ack("post_reset");
    endtask

    task automatic test_hold_and_wrap();
        int cyc;
        sc = '{-27'sd9, -27'sd9, -27'sd9, 27'sd300, -27'sd9, 27'sd299, -27'sd9, -27'sd9, -27'sd9, 27'sd300};
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        check_result("hold_entry");
        for (int i = 0; i < 50; i++) begin
            start       = (i % 2 == 0);
            score_valid = 1'b1;
            score_in    = DW'($urandom);
            @(negedge clk);
            checks++;
            if (predict_valid !== 1'b1 || busy !== 1'b1 || score_ready !== 1'b0 ||
                predict !== last_pred || max_score !== last_max) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b busy=%b ready=%b predict=%0d max=%0d required 1 1 0 %0d %0d",
                         i, predict_valid, busy, score_ready, predict, max_score, last_pred, last_max);
            end
        end
        start = 1'b0; score_valid = 1'b0;
        do_ack("hold");
        force dut.img_count_q = 16'hFFFF;
        #1 release dut.img_count_q;
        exp_cnt = 16'hFFFF;
        checks++;
        if (img_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preset: img_count=%h required ffff", img_count);
        end
        sc = '{27'sd0, 27'sd0, 27'sd0, 27'sd0, 27'sd0, 27'sd0, 27'sd0, 27'sd1, 27'sd0, 27'sd0};
        @(negedge clk);
        push_expected();
        run_beats(1'b0, 1'b0, cyc);
        check_result("wrap");
        do_ack("wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_min();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_hold_and_wrap();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: entries=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/argmax_scheduler.md
ARGMAX_SCHEDULER -- requirements
Module: argmax_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 27, width of one signed class score.
REQ-002 Parameter NUM_CLASS, default 10, number of class scores per frame.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a new frame.
REQ-006 abort  input  1  synchronous frame cancel.
REQ-007 score_in  input  DATA_WIDTH  two's-complement class score, one per beat, class index order 0..NUM_CLASS-1.
REQ-008 score_valid  input  1  score_in carries a beat.
REQ-009 score_ready  output  1  block accepts a beat this cycle.
REQ-010 predict  output  8  winning class index, zero-extended.
REQ-011 max_score  output  DATA_WIDTH  winning score.
REQ-012 predict_valid  output  1  predict and max_score are final.
REQ-013 predict_ack  input  1  consumer takes the result.
REQ-014 busy  output  1  high in COLLECT or DONE.
REQ-015 img_count  output  16  count of acknowledged frames.

Function
REQ-016 The FSM SHALL have three states: IDLE, COLLECT, DONE.
REQ-017 IDLE: score_ready=0; start=1 SHALL move to COLLECT and clear beat index to 0.
REQ-018 COLLECT: score_ready=1; a beat SHALL be accepted only when score_valid and score_ready are both high.
REQ-019 On an accepted beat with index 0, the block SHALL load max_score<=score_in and best index<=0 unconditionally.
REQ-020 On an accepted beat with index>0, the block SHALL replace the stored max and index only if score_in > max_score as signed DATA_WIDTH values (strict greater; ties keep the lower index).
REQ-021 Accepting the beat with index NUM_CLASS-1 SHALL move to DONE; predict_valid SHALL be high on the next cycle with that beat included in the result.
REQ-022 DONE: score_ready=0; predict, max_score and predict_valid SHALL hold stable until predict_ack=1.
REQ-023 predict_ack=1 in DONE SHALL return to IDLE, drop predict_valid, and increment img_count by 1 (wrap 0xFFFF->0x0000).
REQ-024 predict_ack outside DONE, start outside IDLE, and score_valid outside COLLECT SHALL be ignored.
REQ-025 abort=1 in any state SHALL return to IDLE next cycle with predict_valid=0 and no img_count change; abort has priority over start, beat acceptance and predict_ack in the same cycle.
REQ-026 Gaps (score_valid=0) in COLLECT SHALL stall the index without altering the stored max.
REQ-027 predict and max_score SHALL retain their last values in IDLE until overwritten by the next frame's index-0 beat.
REQ-028 Minimum frame time SHALL be 1 (start) + NUM_CLASS beats + 1 (ack) cycles; back-to-back start is legal in the cycle after ack.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, beat index=0, score_ready=0, predict=0, max_score=0, predict_valid=0, busy=0, img_count=0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL require a fresh start.

Structure
REQ-031 Package argmax_pkg SHALL hold DATA_WIDTH, NUM_CLASS, IDX_WIDTH=4, and the state enumeration type.
REQ-032 One sub-module, signed_max_cell, SHALL perform the combinational signed compare/select of (incoming score, index) against (stored max, index).
REQ-033 No combinational path SHALL exist from score_in to any output.

Verification
REQ-034 Scores 0..9 = {5,-3,100,7,100,-1,0,99,2,1}, no gaps, ack next cycle -> predict=2, max_score=100, predict_valid 1 cycle after 10th beat, img_count=1.
REQ-035 All scores = -2^26 (0x4000000) -> predict=0, max_score=0x4000000 (tie rule, signed minimum).
REQ-036 Scores with score[9]=+1 and all others negative, score_valid toggling every other cycle -> predict=9 after 10 accepted beats, 20 cycles of COLLECT.
REQ-037 abort asserted after beat 4 together with score_valid -> IDLE next cycle, predict_valid=0, img_count unchanged, next frame result unaffected.
REQ-038 rst pulsed mid-frame and while predict_valid=1 -> all outputs zero immediately without clock edge; start then full frame completes normally.
REQ-039 Hold predict_ack low 50 cycles in DONE with start pulses -> outputs stable, no new frame; img_count driven to 0xFFFF then one more ack -> 0x0000.
